int8_fp16_conv_arbiter: RTL and testbench
=========================================

// Module: int8_fp16_conv_arbiter
// PURPOSE
//  Shares one int8->fp16 conversion datapath among NUM_REQ requesters, such as activation and weight fetch ports.
//  - Requester selection: round-robin arbitration.
//  - Datapath: two-stage pipeline (grant register, then conversion register).
//  - Flow control: valid/ready handshakes on every requester port and on the output port.
//  - Each result is returned tagged with the requester id.
//  Sits between the int8 operand buffers and the fp16 MAC array.
// PARAMETERS
//  NUM_REQ  4  number of requesters, >=2
//  ID_W     2  width of id tag, = clog2(NUM_REQ)
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          synchronous active-low reset
//  req_valid  in   NUM_REQ    per-requester operand valid
//  req_data   in   8*NUM_REQ  unsigned int8 operands; requester i at [8i+7:8i]
//  req_ready  out  NUM_REQ    per-requester accept
//  out_valid  out  1          converted result valid
//  out_data   out  16         fp16 result {sign,exp[4:0],mant[9:0]}
//  out_id     out  ID_W       requester index of out_data
//  out_ready  in   1          downstream accept
//  busy       out  1          any pipeline stage holds data
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk):
//   - s1_valid=0, s2_valid=0, out_data=16'h0000, out_id=0.
//   - rr_ptr=NUM_REQ-1, so requester 0 has top priority first.
//   - req_ready is all zeros while rst_n=0.
//   - A reset mid-operation silently drops in-flight data.
//  Pipeline advance:
//   - adv2 = ~s2_valid | out_ready.
//   - adv1 = ~s1_valid | adv2.
//  Arbitration (combinational):
//   - Search order is rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
//   - The first i with req_valid[i] wins.
//   - req_ready is one-hot at the winner when adv1=1, else all zeros.
//   - req_ready never depends on out_data.
//  Accept (req_valid[i] & req_ready[i]):
//   - s1 captures the operand and id i; s1_valid=1.
//   - rr_ptr<=i. rr_ptr is updated only on an accept.
//   - If adv1=1 and nothing is accepted, s1_valid<=0.
//  Stage 2:
//   - If adv2=1: s2 <= convert(s1 data), out_id <= s1 id, s2_valid <= s1_valid.
//   - out_valid=s2_valid; out_data and out_id are the s2 registers.
//  Latency and throughput:
//   - 2 cycles from accept edge to out_valid, with out_ready held high.
//   - 1 result per cycle sustained.
//  Backpressure:
//   - out_valid=1 & out_ready=0 holds out_data and out_id stable.
//   - s1 fills, then all req_ready drop. No drop, no duplicate.
//   - Results leave in acceptance order.
//  Conversion (unsigned, exact):
//   - v=0 -> 16'h0000.
//   - Otherwise p = index of the MSB set in v.
//   - exp = p+15 (range 15..22).
//   - mant = (v << (10-p))[9:0].
//   - sign = 0.
//  Boundaries:
//   - All requesters valid -> grants cycle 0,1,2,3,0...
//   - A single requester gets back-to-back grants every cycle.
//   - A requester deasserting valid after its grant is legal.
//   - A requester must hold req_valid and req_data stable until accepted.
//   - busy = s1_valid | s2_valid.
// STRUCTURE
//  Shared package (fp16_pkg):
//   - FP16_EXP_BIAS=15, FP16_ZERO=16'h0000.
//   - fp16_t {sign, exp[4:0], mant[9:0]} typedef.
//  Sub-module int8_fp16_core:
//   - Combinational priority encoder plus shift.
//   - Instantiated once between s1 and s2.
//  Everything else stays in this file: arbiter, rr_ptr, stage registers.
// TESTING
//  - Reset, then req0 data 8'd1 alone -> req_ready[0]=1 at cycle 0; 2 cycles later out_data=16'h3C00, out_id=0.
//  - Conversion sweep via req2: 0->0000, 3->4200, 128->5800, 255->5BF8; all 256 inputs checked against the model.
//  - All 4 requesters valid continuously with out_ready=1 -> out_id sequence 0,1,2,3,0,1... at one result per cycle.
//  - out_ready=0 for 5 cycles with streams active -> out_data held, at most 2 items buffered, req_ready=0; on release, no loss or duplication, order kept.
//  - Only req1 and req3 valid, rr_ptr=1 -> grant order 3,1,3,1; req3 drops valid -> req1 granted every cycle.
//  - rst_n=0 for 1 cycle while both stages are full -> next cycle out_valid=0, busy=0; then req0 is granted first.

Source files
------------

// File: rtl/int8_fp16_conv_arbiter_pkg.sv
// Shared fp16 types and constants for the int8->fp16 conversion arbiter.
package int8_fp16_conv_arbiter_pkg;

    localparam int          FP16_EXP_BIAS = 15;
    localparam logic [15:0] FP16_ZERO     = 16'h0000;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] mant;
    } fp16_t;

endpackage

// File: rtl/int8_fp16_conv_arbiter_if.sv
// Requester-side and result-side handshake bundle of the conversion arbiter.
interface int8_fp16_conv_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 out_valid;
    logic [15:0]          out_data;
    logic [ID_W-1:0]      out_id;
    logic                 out_ready;
    logic                 busy;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id, busy
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id, busy
    );
endinterface

// File: rtl/int8_fp16_conv_arbiter_core.sv
// Exact unsigned int8 -> fp16 conversion: MSB priority encoder plus normalising shift.
module int8_fp16_conv_arbiter_core
    import int8_fp16_conv_arbiter_pkg::*;
(
    input  logic [7:0] i_data,
    output fp16_t      o_fp16
);
    logic [2:0] w_msb;
    logic [9:0] w_norm;

    // Highest set bit wins because later iterations overwrite earlier ones.
    always_comb begin
        w_msb = 3'd0;
        for (int b = 0; b < 8; b++) begin
            w_msb = i_data[b] ? 3'(b) : w_msb;
        end
    end

    // Shifting the operand so its MSB lands on the hidden bit leaves the fraction below it.
    assign w_norm = 10'({i_data, 10'd0} >> w_msb);

    // Assemble the fp16 word; zero has no leading one and maps to +0.
    always_comb begin
        o_fp16 = FP16_ZERO;
        if (i_data != 8'd0) begin
            o_fp16.sign = 1'b0;
            o_fp16.exp  = 5'(w_msb) + 5'(FP16_EXP_BIAS);
            o_fp16.mant = w_norm;
        end else begin
            o_fp16 = FP16_ZERO;
        end
    end
endmodule

// File: rtl/int8_fp16_conv_arbiter.sv
// Round-robin arbiter sharing one int8->fp16 converter among NUM_REQ requesters,
// with a grant stage and a conversion stage, results tagged by requester id.
module int8_fp16_conv_arbiter
    import int8_fp16_conv_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    int8_fp16_conv_arbiter_if.slave bus
);
    logic               r_s1_valid;
    logic [7:0]         r_s1_data;
    logic [ID_W-1:0]    r_s1_id;
    logic               r_s2_valid;
    fp16_t              r_s2_data;
    logic [ID_W-1:0]    r_s2_id;
    logic [ID_W-1:0]    r_rr_ptr;

    logic               w_adv1;
    logic               w_adv2;
    logic               w_found;
    logic [ID_W-1:0]    w_idx;
    logic [ID_W-1:0]    w_win;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_accept;
    fp16_t              w_conv;

    assign w_adv2   = ~r_s2_valid | bus.out_ready;
    assign w_adv1   = ~r_s1_valid | w_adv2;
    assign w_accept = |w_grant;

    // Round-robin search starting just after the last accepted requester.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end else begin
                w_found = w_found;
            end
        end
    end

    // One-hot ready to the winner only when stage 1 can take a new operand.
    always_comb begin
        w_grant = '0;
        if (rst_n && w_found && w_adv1) begin
            w_grant[w_win] = 1'b1;
        end else begin
            w_grant = '0;
        end
    end

    int8_fp16_conv_arbiter_core u_core (
        .i_data (r_s1_data),
        .o_fp16 (w_conv)
    );

    // Grant register, conversion register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= 8'd0;
            r_s1_id    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= FP16_ZERO;
            r_s2_id    <= '0;
            r_rr_ptr   <= ID_W'(NUM_REQ - 1);
        end else begin
            if (w_adv1) begin
                if (w_accept) begin
                    r_s1_valid <= 1'b1;
                    r_s1_data  <= bus.req_data[{w_win, 3'b000} +: 8];
                    r_s1_id    <= w_win;
                    r_rr_ptr   <= w_win;
                end else begin
                    r_s1_valid <= 1'b0;
                end
            end
            if (w_adv2) begin
                r_s2_valid <= r_s1_valid;
                r_s2_data  <= w_conv;
                r_s2_id    <= r_s1_id;
            end
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_data  = r_s2_data;
    assign bus.out_id    = r_s2_id;
    assign bus.busy      = r_s1_valid | r_s2_valid;
endmodule

// File: tb/tb_int8_fp16_conv_arbiter.sv
// Randomised bench for int8_fp16_conv_arbiter against a queue-based reference model.
module tb_int8_fp16_conv_arbiter;

    logic clk;
    logic rst_n;

    int8_fp16_conv_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();

    int8_fp16_conv_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        int          id;
        int          age;
    } item_t;

    item_t       m_q[$];
    int          m_rr;
    logic [3:0]  m_acc;
    bit          m_live;
    int          out_id_log[$];
    logic [15:0] out_d_log[$];
    int          vectors;
    int          miscompares;
    logic [7:0]  sweep_cnt;

    logic [3:0]  exp_ready;
    bit          exp_valid;
    bit          room;
    int          win;
    int          idx;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Plain arithmetic: value = 2^p * (1 + mant/1024).
    function automatic logic [15:0] conv_model(input int v);
        int p;
        int pw;
        if (v == 0) return 16'h0000;
        p  = 0;
        pw = 1;
        while (pw * 2 <= v) begin
            pw = pw * 2;
            p  = p + 1;
        end
        return {1'b0, 5'(p + 15), 10'(((v - pw) * 1024) / pw)};
    endfunction

    // Reference model: capacity-2 in-order buffer, result visible two edges after acceptance.
    always @(negedge clk) begin
        exp_ready = 4'b0000;
        win       = -1;
        if (rst_n) begin
            room = (m_q.size() < 2) || bus.out_ready;
            for (int k = 1; k <= 4; k++) begin
                idx = (m_rr + k) % 4;
                if (win < 0 && bus.req_valid[idx]) win = idx;
            end
            if (room && win >= 0) exp_ready[win] = 1'b1;
        end
        exp_valid = (m_q.size() > 0) && (m_q[0].age >= 2);
        if (m_live) begin
            chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
            chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
            chk("busy", 32'(bus.busy), 32'(m_q.size() > 0));
            if (exp_valid) begin
                chk("out_data", 32'(bus.out_data), 32'(m_q[0].d));
                chk("out_id", 32'(bus.out_id), 32'(m_q[0].id));
            end
        end
        if (!rst_n) begin
            m_q.delete();
            m_rr   = 3;
            m_acc  = 4'b0000;
            m_live = 1'b1;
        end else begin
            if (exp_valid && bus.out_ready) begin
                out_id_log.push_back(m_q[0].id);
                out_d_log.push_back(m_q[0].d);
                void'(m_q.pop_front());
            end
            foreach (m_q[k]) m_q[k].age++;
            if (exp_ready != 4'b0000) begin
                m_q.push_back('{d: conv_model(int'(bus.req_data[8*win +: 8])), id: win, age: 1});
                m_rr = win;
            end
            m_acc = exp_ready;
        end
    end

    task automatic drive(input logic [3:0] mask, input int vpct, input int rpct, input bit sweep);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (!mask[i]) begin
                bus.req_valid[i] = 1'b0;
            end else if (!bus.req_valid[i] || m_acc[i]) begin
                bus.req_valid[i] = ($urandom_range(99) < vpct);
                bus.req_data[8*i +: 8] = sweep ? sweep_cnt : 8'($urandom);
                if (sweep && bus.req_valid[i]) sweep_cnt++;
            end
        end
        bus.out_ready = ($urandom_range(99) < rpct);
    endtask

    task automatic run(input int n, input logic [3:0] mask, input int vpct, input int rpct, input bit sweep);
        for (int c = 0; c < n; c++) drive(mask, vpct, rpct, sweep);
    endtask

    task automatic do_reset(input bit clear_valid);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        if (clear_valid) bus.req_valid = 4'b0000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        m_live        = 1'b0;
        m_rr          = 3;
        m_acc         = 4'b0000;
        sweep_cnt     = 8'd0;
        rst_n         = 1'b0;
        bus.req_valid = 4'b0000;
        bus.req_data  = 32'd0;
        bus.out_ready = 1'b0;

        // Pin the model's conversion rule with hand-computed values.
        chk("model_conv_1", 32'(conv_model(1)), 32'h3C00);
        chk("model_conv_0", 32'(conv_model(0)), 32'h0000);
        chk("model_conv_3", 32'(conv_model(3)), 32'h4200);
        chk("model_conv_128", 32'(conv_model(128)), 32'h5800);
        chk("model_conv_255", 32'(conv_model(255)), 32'h5BF8);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'h0000);
        chk("rst_out_id", 32'(bus.out_id), 32'd0);

        // Single operand 1 from requester 0.
        @(posedge clk);
        #1;
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'h0000_0001;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("first_ready", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1;
        bus.req_valid = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        chk("first_valid", 32'(bus.out_valid), 32'd1);
        chk("first_data", 32'(bus.out_data), 32'h3C00);
        chk("first_id", 32'(bus.out_id), 32'd0);

        // Full conversion sweep through requester 2.
        repeat (3) @(posedge clk);
        out_id_log.delete();
        out_d_log.delete();
        run(262, 4'b0100, 100, 100, 1'b1);
        chk("sweep_count", 32'(out_d_log.size() >= 256), 32'd1);
        if (out_d_log.size() >= 256) begin
            chk("sweep_0", 32'(out_d_log[0]), 32'h0000);
            chk("sweep_3", 32'(out_d_log[3]), 32'h4200);
            chk("sweep_128", 32'(out_d_log[128]), 32'h5800);
            chk("sweep_255", 32'(out_d_log[255]), 32'h5BF8);
        end

        // All requesters streaming: strict rotation at full rate.
        do_reset(1'b1);
        out_id_log.delete();
        run(40, 4'b1111, 100, 100, 1'b0);
        chk("rr_throughput", 32'(out_id_log.size() >= 36), 32'd1);
        if (out_id_log.size() >= 8) begin
            for (int k = 0; k < 8; k++) chk("rr_order", 32'(out_id_log[k]), 32'(k % 4));
        end

        // Backpressure with streams active.
        for (int k = 0; k < 5; k++) begin
            drive(4'b1111, 100, 0, 1'b0);
            @(negedge clk);
            chk("bp_ready", 32'(bus.req_ready), 32'h0);
            chk("bp_busy", 32'(bus.busy), 32'd1);
        end
        run(20, 4'b1111, 100, 100, 1'b0);

        // Requesters 1 and 3 only, then requester 1 alone.
        do_reset(1'b1);
        out_id_log.delete();
        run(12, 4'b1010, 100, 100, 1'b0);
        if (out_id_log.size() >= 6) begin
            for (int k = 0; k < 6; k++) chk("pair_order", 32'(out_id_log[k]), (k % 2 == 0) ? 32'd1 : 32'd3);
        end else begin
            chk("pair_count", 32'(out_id_log.size()), 32'd6);
        end
        run(10, 4'b0010, 100, 100, 1'b0);

        // Reset with both stages full.
        run(6, 4'b1111, 100, 100, 1'b0);
        run(3, 4'b1111, 100, 0, 1'b0);
        do_reset(1'b0);
        @(negedge clk);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'h1);

        // Long random traffic with random backpressure.
        run(3000, 4'b1111, 60, 70, 1'b0);
        run(500, 4'b1111, 90, 30, 1'b0);
        bus.req_valid = 4'b0000;
        run(10, 4'b0000, 0, 100, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
